mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
Parametrised N-port memory arbiter that merges the core's separate instruction-fetch, data-read and data-write request ports onto one shared memory bus. It sits between the core and the memory controller. It supports round-robin or fixed priority, multiple outstanding transactions, and in-order response routing back to the issuing port. It generalises the current point-to-point fetch and data buses and adds arbitration, back-pressure and completion tracking.

Parameters:
NUM_PORTS, 3, number of requesting ports (port 0 = fetch, 1 = data read, 2 = data write in the core build); legal range 2..8.
ADDR_WIDTH, 32, address width.
DATA_WIDTH, 32, data width.
MAX_OUTSTANDING, 4, depth of the in-flight tag FIFO; legal range 1..16.
PRIORITY_MODE, 0, 0 = round-robin, 1 = fixed priority (lowest index wins).

Ports:
clock  in  1  single clock; all logic on its rising edge.
reset  in  1  synchronous, active-high reset.
req_enable  in  NUM_PORTS  per-port request; held until granted.
req_write  in  NUM_PORTS  1 = write, 0 = read.
req_address  in  NUM_PORTS x ADDR_WIDTH  per-port address.
req_data  in  NUM_PORTS x DATA_WIDTH  per-port write data.
req_grant  out  NUM_PORTS  one-hot, one-cycle pulse; the request was accepted by the bus.
resp_valid  out  NUM_PORTS  one-hot, one-cycle pulse; the transaction completed.
resp_data  out  DATA_WIDTH  read data, shared by all ports, qualified by resp_valid.
bus_enable  out  1  bus request valid.
bus_write  out  1  bus request type.
bus_address  out  ADDR_WIDTH  bus request address.
bus_data  out  DATA_WIDTH  bus write data.
bus_ready  in  1  bus accepts the request this cycle.
bus_resp_valid  in  1  in-order completion, one per accepted request.
bus_resp_data  in  DATA_WIDTH  read data (ignored for writes).
outstanding  out  $clog2(MAX_OUTSTANDING+1)  current in-flight count.
protocol_error  out  1  sticky; set when bus_resp_valid arrives with no transaction in flight.

Behaviour:
- Reset (synchronous, active-high): all outputs 0; tag FIFO empty; round-robin pointer = 0; protocol_error cleared. Any in-flight transactions are abandoned, and the memory side shares the same reset.
- Bus request register: bus_enable, bus_write, bus_address and bus_data are registered. Once bus_enable is asserted, all four hold stable until the cycle bus_ready = 1.
- Issue slot is free when either holds:
  - bus_enable = 0, or
  - bus_enable = 1 and bus_ready = 1.
- Arbitration happens in a cycle when the issue slot is free, at least one req_enable bit is set, and the FIFO can accept a push (count < MAX_OUTSTANDING, or a pop occurs the same cycle).
- In an arbitration cycle:
  - The winner's req_grant pulses in that same cycle (combinational from the registered state and inputs).
  - The bus request register loads the winner's fields; bus_enable = 1 from the next cycle.
  - The winner's index is pushed to the tag FIFO.
- Round-robin: the winner is the first requesting port at or after the pointer, wrapping modulo NUM_PORTS. The pointer becomes winner+1 mod NUM_PORTS. Fixed mode leaves the pointer unused.
- Requesters must deassert or change a request only after req_grant. A request withdrawn before grant is legal and is simply not considered.
- Minimum latency: req_enable at cycle t → req_grant at t → bus_enable at t+1 → with bus_ready at t+1, the next grant can occur at t+1 (back-to-back issue at 1 per cycle).
- Response path: on bus_resp_valid, pop the FIFO head, pulse resp_valid[head] and drive resp_data = bus_resp_data in the same cycle (combinational). Every accepted transaction, read or write, produces exactly one resp_valid.
- bus_resp_valid with the FIFO empty: no pop, no resp_valid, protocol_error ← 1 until reset.
- Simultaneous push and pop: count unchanged. This is legal when full and gives full-rate throughput at MAX_OUTSTANDING.
- Count arithmetic: width $clog2(MAX_OUTSTANDING+1). FIFO pointers use width $clog2(MAX_OUTSTANDING), minimum 1, and wrap at MAX_OUTSTANDING (non-power-of-2 depths must wrap explicitly).
- FIFO full with no pop: no grant issued; requests stay pending.

Decomposition:
- Shared package (core package): port-index constants PORT_FETCH = 0, PORT_DREAD = 1, PORT_DWRITE = 2; a bus_req_t packed struct {write, address, data}; a localparam function for the index width (clog2, minimum 1).
- One sub-module: tag_fifo (parametrised depth and width; push/pop/full/empty/count with simultaneous push-pop support).
- Arbitration logic stays inline.

Test Plan:
- Single read: port 1 requests address 0x100; bus_ready is held at 1; bus_resp_data = 0xDEADBEEF returned 3 cycles later → req_grant[1] pulses at t, bus_enable at t+1 with address 0x100, resp_valid[1] pulses with resp_data 0xDEADBEEF, outstanding returns to 0.
- Round-robin fairness: all 3 ports request continuously with bus_ready = 1 → grant order 0, 1, 2, 0, 1, 2. With PRIORITY_MODE = 1 → port 0 is granted every cycle.
- Back-pressure: bus_ready = 0 for 5 cycles → bus request fields stay stable and no further req_grant occurs until bus_ready rises.
- Full FIFO: MAX_OUTSTANDING = 4 with no responses → exactly 4 grants, then a stall. The first bus_resp_valid enables a 5th grant in the same cycle, and outstanding stays at 4.
- Mixed in-order routing: grants to ports 2 (write), 0 and 1 → three responses route to resp_valid[2], then [0], then [1].
- Error and reset: bus_resp_valid while empty → protocol_error = 1 sticky. A reset pulse with 2 transactions outstanding → all outputs 0, outstanding = 0, and protocol_error cleared.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// rtl/mem_arbiter_pkg.sv - shared port indices, bus request type and index-width helper
// Contents: PORT_* indices of the core build, core bus widths, bus_req_t, idx_width().
package mem_arbiter_pkg;

  localparam int PORT_FETCH  = 0;
  localparam int PORT_DREAD  = 1;
  localparam int PORT_DWRITE = 2;

  localparam int BUS_ADDR_WIDTH = 32;
  localparam int BUS_DATA_WIDTH = 32;

  typedef struct packed {
    logic                      write;
    logic [BUS_ADDR_WIDTH-1:0] address;
    logic [BUS_DATA_WIDTH-1:0] data;
  } bus_req_t;

  // Width of an index into n entries; never below 1 so a depth of 1 still has a pointer bit.
  function automatic int idx_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - core-side request/response and memory-side bus interfaces
// mem_arbiter_req_if: req_enable/req_write/req_address/req_data (core->arbiter),
//   req_grant/resp_valid/resp_data (arbiter->core); master = core, slave = arbiter.
// mem_arbiter_bus_if: bus_enable/bus_write/bus_address/bus_data (arbiter->memory),
//   bus_ready/bus_resp_valid/bus_resp_data (memory->arbiter); master = arbiter, slave = memory.
interface mem_arbiter_req_if #(
  parameter int NUM_PORTS  = 3,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic [NUM_PORTS-1:0]                 req_enable;
  logic [NUM_PORTS-1:0]                 req_write;
  logic [NUM_PORTS-1:0][ADDR_WIDTH-1:0] req_address;
  logic [NUM_PORTS-1:0][DATA_WIDTH-1:0] req_data;
  logic [NUM_PORTS-1:0]                 req_grant;
  logic [NUM_PORTS-1:0]                 resp_valid;
  logic [DATA_WIDTH-1:0]                resp_data;

  modport master (
    output req_enable, req_write, req_address, req_data,
    input  req_grant, resp_valid, resp_data
  );

  modport slave (
    input  req_enable, req_write, req_address, req_data,
    output req_grant, resp_valid, resp_data
  );
endinterface

interface mem_arbiter_bus_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  bus_enable;
  logic                  bus_write;
  logic [ADDR_WIDTH-1:0] bus_address;
  logic [DATA_WIDTH-1:0] bus_data;
  logic                  bus_ready;
  logic                  bus_resp_valid;
  logic [DATA_WIDTH-1:0] bus_resp_data;

  modport master (
    output bus_enable, bus_write, bus_address, bus_data,
    input  bus_ready, bus_resp_valid, bus_resp_data
  );

  modport slave (
    input  bus_enable, bus_write, bus_address, bus_data,
    output bus_ready, bus_resp_valid, bus_resp_data
  );
endinterface

// File: rtl/mem_arbiter_tag_fifo.sv
// rtl/mem_arbiter_tag_fifo.sv - in-flight tag FIFO with same-cycle push/pop
// Ports: clock, reset (sync, active-high), push/push_data, pop, head (current front entry),
//   full, empty, count. Pop must only be asserted when not empty; push when full only together with pop.
module tag_fifo
  import mem_arbiter_pkg::*;
#(
  parameter  int DEPTH = 4,
  parameter  int WIDTH = 2,
  localparam int PW    = idx_width(DEPTH),
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;

  // Explicit wrap so non-power-of-two depths never step past the last entry.
  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_ff @(posedge clock) begin
    if (push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= next_ptr(wr_ptr);
      end
      if (pop) begin
        rd_ptr <= next_ptr(rd_ptr);
      end
      if (push && !pop) begin
        count <= count + CW'(1);
      end else if (pop && !push) begin
        count <= count - CW'(1);
      end
    end
  end

  assign head  = mem[rd_ptr];
  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - N-port memory arbiter with outstanding-transaction tracking
// Ports: clock, reset (sync, active-high); req (core side, slave modport): per-port requests,
//   one-hot req_grant and resp_valid, shared resp_data; bus (memory side, master modport):
//   registered bus request held until bus_ready, in-order bus responses;
//   outstanding = in-flight count; protocol_error = sticky response-without-request flag.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter  int NUM_PORTS       = 3,
  parameter  int ADDR_WIDTH      = BUS_ADDR_WIDTH,
  parameter  int DATA_WIDTH      = BUS_DATA_WIDTH,
  parameter  int MAX_OUTSTANDING = 4,
  parameter  int PRIORITY_MODE   = 0,
  localparam int PIW             = idx_width(NUM_PORTS),
  localparam int CW              = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic              clock,
  input  logic              reset,
  mem_arbiter_req_if.slave  req,
  mem_arbiter_bus_if.master bus,
  output logic [CW-1:0]     outstanding,
  output logic              protocol_error
);

  if (ADDR_WIDTH != BUS_ADDR_WIDTH || DATA_WIDTH != BUS_DATA_WIDTH ||
      NUM_PORTS < 2 || NUM_PORTS > 8 ||
      MAX_OUTSTANDING < 1 || MAX_OUTSTANDING > 16) begin : g_bad_params
    $error("mem_arbiter: unsupported parameter combination");
  end

  bus_req_t       bus_q;
  logic           bus_en_q;
  logic [PIW-1:0] rr_ptr;

  logic           fifo_full;
  logic           fifo_empty;
  logic [PIW-1:0] fifo_head;

  logic           slot_free;
  logic           pop;
  logic           arb;
  logic           found;
  logic [PIW-1:0] win;
  logic [PIW-1:0] cand;
  int             base;
  int             scan;

  // Scan from the round-robin pointer (or from 0 in fixed mode) and take the first requester.
  always_comb begin
    found = 1'b0;
    win   = '0;
    cand  = '0;
    base  = (PRIORITY_MODE != 0) ? 0 : int'(rr_ptr);
    scan  = 0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      scan = base + i;
      if (scan >= NUM_PORTS) begin
        scan = scan - NUM_PORTS;
      end
      cand = PIW'(scan);
      if (!found && req.req_enable[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

  // Issue slot frees in the same cycle the held request is accepted, giving 1/cycle issue.
  // A pop in the same cycle makes room for a push even when the tag FIFO is full.
  always_comb begin
    slot_free = !bus_en_q || bus.bus_ready;
    pop       = !reset && bus.bus_resp_valid && !fifo_empty;
    arb       = !reset && slot_free && found && (!fifo_full || pop);
  end

  always_comb begin
    req.req_grant  = arb ? (NUM_PORTS'(1) << win) : '0;
    req.resp_valid = pop ? (NUM_PORTS'(1) << fifo_head) : '0;
    req.resp_data  = pop ? bus.bus_resp_data : '0;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      bus_en_q       <= 1'b0;
      bus_q          <= '0;
      rr_ptr         <= '0;
      protocol_error <= 1'b0;
    end else begin
      if (arb) begin
        bus_en_q <= 1'b1;
        bus_q    <= '{write:   req.req_write[win],
                      address: req.req_address[win],
                      data:    req.req_data[win]};
        rr_ptr   <= (win == PIW'(NUM_PORTS - 1)) ? '0 : win + PIW'(1);
      end else if (bus_en_q && bus.bus_ready) begin
        bus_en_q <= 1'b0;
      end
      if (bus.bus_resp_valid && fifo_empty) begin
        protocol_error <= 1'b1;
      end
    end
  end

  assign bus.bus_enable  = bus_en_q;
  assign bus.bus_write   = bus_q.write;
  assign bus.bus_address = bus_q.address;
  assign bus.bus_data    = bus_q.data;

  tag_fifo #(
    .DEPTH (MAX_OUTSTANDING),
    .WIDTH (PIW)
  ) u_tags (
    .clock     (clock),
    .reset     (reset),
    .push      (arb),
    .push_data (win),
    .pop       (pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (outstanding)
  );

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - self-checking bench for mem_arbiter (round-robin and fixed-priority instances)
`timescale 1ns/1ps
module tb_mem_arbiter;

  localparam int NP = 3;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int MO = 4;
  localparam int CW = $clog2(MO + 1);

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  mem_arbiter_req_if #(.NUM_PORTS(NP), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) req_r ();
  mem_arbiter_req_if #(.NUM_PORTS(NP), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) req_f ();
  mem_arbiter_bus_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus_r ();
  mem_arbiter_bus_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus_f ();

  logic [CW-1:0] outstanding_r;
  logic [CW-1:0] outstanding_f;
  logic          perr_r;
  logic          perr_f;

  mem_arbiter #(.NUM_PORTS(NP), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
                .MAX_OUTSTANDING(MO), .PRIORITY_MODE(0)) dut (
    .clock(clock), .reset(reset), .req(req_r.slave), .bus(bus_r.master),
    .outstanding(outstanding_r), .protocol_error(perr_r));

  mem_arbiter #(.NUM_PORTS(NP), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
                .MAX_OUTSTANDING(MO), .PRIORITY_MODE(1)) dut_fixed (
    .clock(clock), .reset(reset), .req(req_f.slave), .bus(bus_f.master),
    .outstanding(outstanding_f), .protocol_error(perr_f));

  assign req_f.req_enable    = req_r.req_enable;
  assign req_f.req_write     = req_r.req_write;
  assign req_f.req_address   = req_r.req_address;
  assign req_f.req_data      = req_r.req_data;
  assign bus_f.bus_ready     = bus_r.bus_ready;
  assign bus_f.bus_resp_data = '0;

  logic [AW-1:0] port_addr [NP];
  logic [DW-1:0] port_wdata [NP];

  function automatic logic [DW-1:0] data_for(input logic [AW-1:0] a);
    return (a == 32'h100) ? 32'hDEADBEEF : ((a ^ 32'h5A5A_0000) + 32'h11);
  endfunction

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Memory model for the round-robin instance: in-order responses after mem_lat cycles.
  typedef struct {
    int            due;
    logic [DW-1:0] data;
  } mresp_t;
  mresp_t mq [$];
  int     cycle   = 0;
  int     mem_lat = 1;
  bit     mem_hold = 1'b0;
  bit     inject   = 1'b0;

  initial begin
    bus_r.bus_resp_valid = 1'b0;
    bus_r.bus_resp_data  = '0;
    forever begin
      @(posedge clock);
      cycle++;
      if (reset) begin
        mq.delete();
      end else begin
        if (bus_r.bus_resp_valid && !inject && mq.size() > 0) mq.delete(0);
        if (bus_r.bus_enable && bus_r.bus_ready)
          mq.push_back('{due: cycle + mem_lat, data: data_for(bus_r.bus_address)});
      end
      #2;
      if (!reset && !mem_hold && mq.size() > 0 && mq[0].due <= cycle) begin
        bus_r.bus_resp_valid = 1'b1;
        bus_r.bus_resp_data  = mq[0].data;
      end else if (inject) begin
        bus_r.bus_resp_valid = 1'b1;
        bus_r.bus_resp_data  = 32'hBAD0_0000;
      end else begin
        bus_r.bus_resp_valid = 1'b0;
        bus_r.bus_resp_data  = '0;
      end
    end
  end

  // Fixed-priority instance memory: answers every accepted request one cycle later.
  logic f_acc;
  initial begin
    bus_f.bus_resp_valid = 1'b0;
    forever begin
      @(posedge clock);
      f_acc = !reset && bus_f.bus_enable && bus_f.bus_ready;
      #2;
      bus_f.bus_resp_valid = f_acc;
    end
  end

  // Response scoreboard.
  typedef struct {
    int            port;
    logic [DW-1:0] data;
  } exp_t;
  exp_t exp_q [$];

  task automatic expect_resp(input int p);
    exp_q.push_back('{port: p, data: data_for(port_addr[p])});
  endtask

  always @(negedge clock) begin : sb
    exp_t e;
    if (!reset && req_r.resp_valid != '0) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL resp_unexpected: got resp_valid=%b expected none", req_r.resp_valid);
      end else begin
        e = exp_q.pop_front();
        check("resp_port", 32'(req_r.resp_valid), 32'(1) << e.port);
        check("resp_data", req_r.resp_data, e.data);
      end
    end
  end

  task automatic wait_drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 40) begin
      @(negedge clock);
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s: got %0d responses pending expected 0", name, exp_q.size());
    end
  endtask

  task automatic drive(input logic [NP-1:0] en);
    @(posedge clock);
    #1;
    req_r.req_enable = en;
  endtask

  typedef struct {
    logic [NP-1:0] en;
    logic [NP-1:0] g_rr;
    logic [NP-1:0] g_fx;
  } vec_t;
  vec_t vecs [11];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach the summary");
    $fatal(1);
  end

  initial begin
    int ngrant;
    port_addr[0]  = 32'h2000;
    port_addr[1]  = 32'h0100;
    port_addr[2]  = 32'h3000;
    port_wdata[0] = 32'hD000_0000;
    port_wdata[1] = 32'hD000_0001;
    port_wdata[2] = 32'hD000_0002;
    for (int p = 0; p < NP; p++) begin
      req_r.req_address[p] = port_addr[p];
      req_r.req_data[p]    = port_wdata[p];
    end
    req_r.req_write  = 3'b100;
    req_r.req_enable = '0;
    bus_r.bus_ready  = 1'b1;

    // Sequence from reset (pointer 0): {enables, round-robin grant, fixed grant}.
    vecs[0]  = '{3'b111, 3'b001, 3'b001};
    vecs[1]  = '{3'b111, 3'b010, 3'b001};
    vecs[2]  = '{3'b111, 3'b100, 3'b001};
    vecs[3]  = '{3'b111, 3'b001, 3'b001};
    vecs[4]  = '{3'b111, 3'b010, 3'b001};
    vecs[5]  = '{3'b111, 3'b100, 3'b001};
    vecs[6]  = '{3'b100, 3'b100, 3'b100};
    vecs[7]  = '{3'b110, 3'b010, 3'b010};
    vecs[8]  = '{3'b011, 3'b001, 3'b001};
    vecs[9]  = '{3'b000, 3'b000, 3'b000};
    vecs[10] = '{3'b101, 3'b100, 3'b001};

    // Reset state, sampled while reset is still asserted.
    repeat (2) @(posedge clock);
    @(negedge clock);
    check("rst_bus_enable", 32'(bus_r.bus_enable), 0);
    check("rst_bus_address", bus_r.bus_address, 0);
    check("rst_req_grant", 32'(req_r.req_grant), 0);
    check("rst_resp_valid", 32'(req_r.resp_valid), 0);
    check("rst_outstanding", 32'(outstanding_r), 0);
    check("rst_protocol_error", 32'(perr_r), 0);
    @(posedge clock);
    #1;
    reset = 1'b0;

    // Arbitration table.
    mem_lat = 1;
    for (int v = 0; v < 11; v++) begin
      drive(vecs[v].en);
      @(negedge clock);
      check($sformatf("rr_grant[%0d]", v), 32'(req_r.req_grant), 32'(vecs[v].g_rr));
      check($sformatf("fx_grant[%0d]", v), 32'(req_f.req_grant), 32'(vecs[v].g_fx));
      for (int p = 0; p < NP; p++) if (vecs[v].g_rr[p]) expect_resp(p);
    end
    drive('0);
    wait_drain("table_drain");

    // Single read with 3-cycle memory latency.
    mem_lat = 3;
    drive(3'b010);
    @(negedge clock);
    check("sr_grant", 32'(req_r.req_grant), 32'b010);
    check("sr_bus_idle", 32'(bus_r.bus_enable), 0);
    expect_resp(1);
    drive('0);
    @(negedge clock);
    check("sr_bus_enable", 32'(bus_r.bus_enable), 1);
    check("sr_bus_address", bus_r.bus_address, 32'h100);
    check("sr_bus_write", 32'(bus_r.bus_write), 0);
    check("sr_outstanding", 32'(outstanding_r), 1);
    wait_drain("sr_drain");
    @(negedge clock);
    check("sr_outstanding_idle", 32'(outstanding_r), 0);

    // Back-pressure: request held stable, no grant while bus_ready is low.
    mem_lat = 1;
    @(posedge clock);
    #1;
    bus_r.bus_ready  = 1'b0;
    req_r.req_enable = 3'b001;
    @(negedge clock);
    check("bp_grant0", 32'(req_r.req_grant), 32'b001);
    expect_resp(0);
    for (int k = 0; k < 5; k++) begin
      drive(3'b100);
      @(negedge clock);
      check("bp_no_grant", 32'(req_r.req_grant), 0);
      check("bp_enable_held", 32'(bus_r.bus_enable), 1);
      check("bp_address_held", bus_r.bus_address, port_addr[0]);
      check("bp_data_held", bus_r.bus_data, port_wdata[0]);
    end
    @(posedge clock);
    #1;
    bus_r.bus_ready = 1'b1;
    @(negedge clock);
    check("bp_grant2", 32'(req_r.req_grant), 32'b100);
    expect_resp(2);
    drive('0);
    @(negedge clock);
    check("bp_next_address", bus_r.bus_address, port_addr[2]);
    check("bp_next_write", 32'(bus_r.bus_write), 1);
    wait_drain("bp_drain");

    // Full FIFO: four grants, then stall until the first response frees a slot.
    mem_hold = 1'b1;
    for (int k = 0; k < 5; k++) expect_resp(0);
    drive(3'b001);
    ngrant = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clock);
      if (req_r.req_grant[0]) ngrant++;
    end
    check("full_grant_count", 32'(ngrant), 4);
    check("full_outstanding", 32'(outstanding_r), 4);
    check("full_stalled", 32'(req_r.req_grant), 0);
    @(posedge clock);
    #1;
    mem_hold = 1'b0;
    @(negedge clock);
    check("full_5th_grant", 32'(req_r.req_grant), 32'b001);
    drive('0);
    @(negedge clock);
    check("full_swap_outstanding", 32'(outstanding_r), 4);
    wait_drain("full_drain");

    // Mixed in-order routing: write on port 2, then reads on 0 and 1.
    mem_lat = 4;
    drive(3'b100);
    @(negedge clock);
    check("mix_grant2", 32'(req_r.req_grant), 32'b100);
    expect_resp(2);
    drive(3'b001);
    @(negedge clock);
    check("mix_grant0", 32'(req_r.req_grant), 32'b001);
    check("mix_bus_write", 32'(bus_r.bus_write), 1);
    expect_resp(0);
    drive(3'b010);
    @(negedge clock);
    check("mix_grant1", 32'(req_r.req_grant), 32'b010);
    check("mix_bus_address", bus_r.bus_address, port_addr[0]);
    expect_resp(1);
    drive('0);
    wait_drain("mix_drain");

    // Response with nothing in flight.
    @(posedge clock);
    #1;
    inject = 1'b1;
    @(negedge clock);
    check("err_no_resp", 32'(req_r.resp_valid), 0);
    check("err_not_yet", 32'(perr_r), 0);
    @(posedge clock);
    #1;
    inject = 1'b0;
    @(negedge clock);
    check("err_set", 32'(perr_r), 1);
    repeat (3) @(negedge clock);
    check("err_sticky", 32'(perr_r), 1);

    // Reset with two transactions in flight.
    mem_lat  = 1;
    mem_hold = 1'b1;
    drive(3'b001);
    drive(3'b001);
    drive('0);
    @(negedge clock);
    check("rst2_outstanding_before", 32'(outstanding_r), 2);
    @(posedge clock);
    #1;
    reset = 1'b1;
    exp_q.delete();
    @(posedge clock);
    #1;
    reset    = 1'b0;
    mem_hold = 1'b0;
    @(negedge clock);
    check("rst2_outstanding", 32'(outstanding_r), 0);
    check("rst2_protocol_error", 32'(perr_r), 0);
    check("rst2_bus_enable", 32'(bus_r.bus_enable), 0);
    check("rst2_bus_address", bus_r.bus_address, 0);
    check("rst2_bus_data", bus_r.bus_data, 0);
    check("rst2_resp_valid", 32'(req_r.resp_valid), 0);
    check("rst2_resp_data", req_r.resp_data, 0);

    // Pointer restarts at port 0 after reset.
    drive(3'b111);
    @(negedge clock);
    check("rst2_rr_restart", 32'(req_r.req_grant), 32'b001);
    expect_resp(0);
    drive('0);
    wait_drain("final_drain");
    @(negedge clock);
    check("final_outstanding", 32'(outstanding_r), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
